axi_lite_ctrl_master: RTL and testbench

- Single-outstanding AXI-Lite master (initiator) that turns a simple command/response stream into AXI-Lite read and write transactions.
- It is the counterpart to the application control slaves: it lets shell- or app-side logic drive control registers (e.g. behind the control clock crossing) without hand-coding AXI-Lite handshakes.
- Includes a response timeout so a hung slave never deadlocks the caller.

---
 rtl/axi_lite_ctrl_master_if.sv | 35 +++
 rtl/axi_lite_ctrl_master.sv | 183 ++++++++++++++++++
 tb/tb_axi_lite_ctrl_master.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_ctrl_master_if.sv
// AXI-Lite bus bundle used by the command-driven control master.
// The master modport is the initiator side; the slave modport is the target side.
interface axi_lite_ctrl_master_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_ctrl_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one AXI-Lite transaction out,
// one response back, with a per-transaction timeout and a drain of late handshakes.
module axi_lite_ctrl_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic        cmd_rnw,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        rsp_is_read,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        busy,
  axi_lite_ctrl_master_if.master m_axi_lite
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN} state_t;

  localparam int unsigned TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TO_LAST_INT);

  state_t                   state_reg;
  logic [TIMEOUT_WIDTH-1:0] count_reg;
  logic                     resp_pending_reg;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_left, w_left, ar_left, resp_left, any_left;
  logic axi_phase, progress, timeout_fire;

  assign m_axi_lite.awprot = 3'b000;
  assign m_axi_lite.arprot = 3'b000;

  assign aw_hs = m_axi_lite.awvalid && m_axi_lite.awready;
  assign w_hs  = m_axi_lite.wvalid  && m_axi_lite.wready;
  assign ar_hs = m_axi_lite.arvalid && m_axi_lite.arready;
  assign b_hs  = m_axi_lite.bvalid  && m_axi_lite.bready;
  assign r_hs  = m_axi_lite.rvalid  && m_axi_lite.rready;

  // "left" = still outstanding after this cycle's handshakes
  assign aw_left   = m_axi_lite.awvalid && !aw_hs;
  assign w_left    = m_axi_lite.wvalid  && !w_hs;
  assign ar_left   = m_axi_lite.arvalid && !ar_hs;
  assign resp_left = resp_pending_reg && !(b_hs || r_hs);
  assign any_left  = aw_left || w_left || ar_left || resp_left;

  assign axi_phase = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
                     (state_reg == RD_REQ) || (state_reg == RD_RESP);
  assign progress  = ((state_reg == WR_REQ)  && !aw_left && !w_left) ||
                     ((state_reg == WR_RESP) && b_hs) ||
                     ((state_reg == RD_REQ)  && ar_hs) ||
                     ((state_reg == RD_RESP) && r_hs);
  // >= rather than == so a phase change landing on the last cycle cannot skip the limit
  assign timeout_fire = (TIMEOUT_CYCLES != 0) && axi_phase && !progress &&
                        (count_reg >= TO_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg          <= IDLE;
      count_reg          <= '0;
      resp_pending_reg   <= 1'b0;
      cmd_ready          <= 1'b1;
      busy               <= 1'b0;
      rsp_rdata          <= '0;
      rsp_resp           <= 2'b00;
      rsp_timeout        <= 1'b0;
      rsp_is_read        <= 1'b0;
      rsp_valid          <= 1'b0;
      m_axi_lite.awaddr  <= '0;
      m_axi_lite.awvalid <= 1'b0;
      m_axi_lite.wdata   <= '0;
      m_axi_lite.wstrb   <= '0;
      m_axi_lite.wvalid  <= 1'b0;
      m_axi_lite.bready  <= 1'b0;
      m_axi_lite.araddr  <= '0;
      m_axi_lite.arvalid <= 1'b0;
      m_axi_lite.rready  <= 1'b0;
    end else begin
      if (aw_hs) m_axi_lite.awvalid <= 1'b0;
      if (w_hs)  m_axi_lite.wvalid  <= 1'b0;
      if (ar_hs) m_axi_lite.arvalid <= 1'b0;
      if (b_hs || r_hs) resp_pending_reg <= 1'b0;
      if (axi_phase) count_reg <= count_reg + TIMEOUT_WIDTH'(1);

      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready        <= 1'b0;
            busy             <= 1'b1;
            count_reg        <= '0;
            resp_pending_reg <= 1'b1;
            rsp_is_read      <= cmd_rnw;
            if (cmd_rnw) begin
              m_axi_lite.araddr  <= cmd_addr;
              m_axi_lite.arvalid <= 1'b1;
              state_reg          <= RD_REQ;
            end else begin
              m_axi_lite.awaddr  <= cmd_addr;
              m_axi_lite.wdata   <= cmd_wdata;
              m_axi_lite.wstrb   <= cmd_wstrb;
              m_axi_lite.awvalid <= 1'b1;
              m_axi_lite.wvalid  <= 1'b1;
              state_reg          <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (!aw_left && !w_left) begin
            m_axi_lite.bready <= 1'b1;
            state_reg         <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            m_axi_lite.bready <= 1'b0;
            rsp_rdata         <= '0;
            rsp_resp          <= m_axi_lite.bresp;
            rsp_timeout       <= 1'b0;
            rsp_valid         <= 1'b1;
            state_reg         <= RSP;
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            m_axi_lite.rready <= 1'b1;
            state_reg         <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            m_axi_lite.rready <= 1'b0;
            rsp_rdata         <= m_axi_lite.rdata;
            rsp_resp          <= m_axi_lite.rresp;
            rsp_timeout       <= 1'b0;
            rsp_valid         <= 1'b1;
            state_reg         <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (any_left) begin
              state_reg <= DRAIN;
            end else begin
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        DRAIN: begin
          // late response is accepted only once its request side has gone out
          m_axi_lite.bready <= resp_left && !rsp_is_read && !aw_left && !w_left;
          m_axi_lite.rready <= resp_left && rsp_is_read && !ar_left;
          if (!any_left) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (timeout_fire) begin
        m_axi_lite.bready <= 1'b0;
        m_axi_lite.rready <= 1'b0;
        rsp_rdata         <= '0;
        rsp_resp          <= 2'b10;
        rsp_timeout       <= 1'b1;
        rsp_valid         <= 1'b1;
        state_reg         <= RSP;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_ctrl_master.sv
// Randomized bench for axi_lite_ctrl_master: a delay-driven AXI-Lite slave plus a
// reference model that predicts each response from the slave's delay schedule.
module tb_axi_lite_ctrl_master;
  localparam int TO = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_rnw = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        rsp_is_read;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  axi_lite_ctrl_master_if axi ();

  axi_lite_ctrl_master #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(16)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .cmd_rnw    (cmd_rnw),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .rsp_is_read(rsp_is_read),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .m_axi_lite (axi)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic slave_idle();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0;  axi.bresp = 2'b00;
    axi.rvalid = 1'b0;  axi.rresp = 2'b00; axi.rdata = '0;
    rsp_ready = 1'b0;
  endtask

  // Delays are in cycles counted from the first cycle the request valids are up.
  // The transaction completes at cycle f; it beats the timeout iff f <= TO-1.
  task automatic run_txn(input bit rnw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int d_aw, input int d_w, input int d_b,
                         input int d_ar, input int d_r, input logic [1:0] sresp,
                         input logic [31:0] srdata, input int d_rsp);
    int f, t, aw_t, w_t, ar_t, rsp_t, rsp_hs;
    bit exp_to, aw_done, w_done, b_done, ar_done, r_done, rsp_seen, finished;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;

    f         = rnw ? d_ar + 1 + d_r : ((d_aw > d_w) ? d_aw : d_w) + 1 + d_b;
    exp_to    = (f > TO - 1);
    exp_resp  = exp_to ? 2'b10 : sresp;
    exp_rdata = (exp_to || !rnw) ? 32'h0 : srdata;

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb; cmd_rnw = rnw; cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    check("cmd_ready_taken", cmd_ready, 0);
    check("busy_taken", busy, 1);
    if (rnw) begin
      check("arvalid_issue", axi.arvalid, 1);
      check("araddr", axi.araddr, addr);
    end else begin
      check("aw_w_valid_issue", {axi.awvalid, axi.wvalid}, 2'b11);
      check("awaddr", axi.awaddr, addr);
      check("wdata", axi.wdata, wdata);
      check("wstrb", axi.wstrb, wstrb);
    end

    aw_done = rnw; w_done = rnw; b_done = rnw; ar_done = !rnw; r_done = !rnw;
    aw_t = 0; w_t = 0; ar_t = 0; rsp_t = 0; rsp_hs = 0; rsp_seen = 0; finished = 0; t = 0;
    while (!finished && t < 300) begin
      if (aw_done && w_done && b_done && ar_done && r_done && rsp_hs > 0 && !busy) begin
        check("cmd_ready_back", cmd_ready, 1);
        finished = 1;
      end else begin
        check("awvalid_hold", axi.awvalid, !aw_done);
        check("wvalid_hold", axi.wvalid, !w_done);
        check("arvalid_hold", axi.arvalid, !ar_done);
        check("bready_early", axi.bready && !(aw_done && w_done), 0);
        check("rready_early", axi.rready && !ar_done, 0);
        check("bready_extra", axi.bready && b_done, 0);
        check("rready_extra", axi.rready && r_done, 0);

        if (rsp_valid) begin
          if (!rsp_seen) begin
            rsp_seen = 1;
            rsp_t = t;
          end
          check("rsp_once", rsp_hs, 0);
          check("rsp_rdata", rsp_rdata, exp_rdata);
          check("rsp_resp", rsp_resp, exp_resp);
          check("rsp_timeout", rsp_timeout, exp_to);
          check("rsp_is_read", rsp_is_read, rnw);
        end
        rsp_ready = rsp_valid && (t - rsp_t >= d_rsp);
        if (rsp_ready) rsp_hs++;

        axi.awready = axi.awvalid && !aw_done && (t >= d_aw);
        if (axi.awready) begin aw_done = 1; aw_t = t; end
        axi.wready = axi.wvalid && !w_done && (t >= d_w);
        if (axi.wready) begin w_done = 1; w_t = t; end
        axi.arready = axi.arvalid && !ar_done && (t >= d_ar);
        if (axi.arready) begin ar_done = 1; ar_t = t; end

        axi.bresp  = sresp;
        axi.bvalid = !b_done && aw_done && w_done && (t >= ((aw_t > w_t) ? aw_t : w_t) + 1 + d_b);
        if (axi.bvalid && axi.bready) b_done = 1;
        axi.rresp  = sresp;
        axi.rdata  = srdata;
        axi.rvalid = !r_done && ar_done && (t >= ar_t + 1 + d_r);
        if (axi.rvalid && axi.rready) r_done = 1;

        @(negedge aclk);
        t++;
      end
    end
    if (!finished) check("txn_bound", 0, 1);
    check("rsp_count", rsp_hs, 1);
    $display("txn %s addr=%h to=%0d resp=%0d rdata=%h f=%0d", rnw ? "RD" : "WR", addr,
             exp_to, exp_resp, exp_rdata, f);
    slave_idle();
  endtask

  function automatic int rand_delay(input int lo_max, input int hang);
    return ($urandom_range(0, 5) == 0) ? hang : int'($urandom_range(0, lo_max));
  endfunction

  initial begin
    slave_idle();
    repeat (2) @(negedge aclk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", {rsp_rdata, rsp_resp, rsp_timeout, rsp_is_read}, 0);
    aresetn = 1'b1;
    @(negedge aclk);

    // write with immediate readies
    run_txn(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 0, 0, 2'b00, 32'h0, 0);
    // wready five cycles after awready
    run_txn(0, 32'h0000_0020, 32'h0BAD_F00D, 4'h3, 0, 5, 0, 0, 0, 2'b00, 32'h0, 1);
    // read, held response
    run_txn(1, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 32'h1234_5678, 4);
    // arready withheld past the limit, late data must be swallowed
    run_txn(1, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 0, 12, 1, 2'b00, 32'hAAAA_AAAA, 1);
    // SLVERR write
    run_txn(0, 32'h0000_0030, 32'h1111_2222, 4'hF, 1, 0, 0, 0, 0, 2'b10, 32'h0, 0);
    // completion on the final allowed cycle, then one cycle too late
    run_txn(1, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 0, 2, 4, 2'b01, 32'hCAFE_0001, 0);
    run_txn(1, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 0, 3, 4, 2'b00, 32'hCAFE_0002, 0);
    // write response withheld past the limit
    run_txn(0, 32'h0000_0050, 32'h5555_5555, 4'hC, 2, 1, 12, 0, 0, 2'b00, 32'h0, 2);

    // reset while the write request is outstanding
    cmd_addr = 32'h0000_0060; cmd_wdata = 32'h7777_7777; cmd_wstrb = 4'hF;
    cmd_rnw = 1'b0; cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    check("pre_rst_awvalid", axi.awvalid, 1);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_aw_w", {axi.awvalid, axi.wvalid}, 2'b00);
    check("rst_mid_busy", busy, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    $display("txn RESET mid-write");
    run_txn(1, 32'h0000_0064, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b00, 32'h9876_5432, 0);

    for (int i = 0; i < 50; i++) begin
      bit rnw;
      rnw = 1'($urandom_range(0, 1));
      run_txn(rnw, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
              rand_delay(5, 12), rand_delay(5, 12), rand_delay(2, 12),
              rand_delay(3, 12), rand_delay(4, 12),
              2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
